wm_sense_timer: RTL and testbench
=================================

# wm_sense_timer

Plant-side sensor and timer model for the washing-machine controller. It consumes the controller's actuator outputs (motor_on, fill_value_on, drain_value_on, done) and produces the controller's status inputs (filled, drained, cycle_timeout, spin_timeout). Internally it models the water level, the wash-cycle timer and the spin timer against a prescaled tick, closing the loop for on-chip operation and test.

## Interface

- TICK_DIV, 10: clocks per timebase tick; legal range ≥1.
- LEVEL_MAX, 20: level count at which the drum is full; legal range 1..255.
- CYCLE_TICKS, 100: motor ticks per wash cycle; legal range ≥1.
- SPIN_TICKS, 50: ticks per spin phase; legal range ≥1.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high; clock clk.
- enable  in  1  timebase enable. 0 freezes all counters.
- motor_on  in  1  drum motor running.
- fill_value_on  in  1  fill valve open.
- drain_value_on  in  1  drain valve open.
- done  in  1  end of wash programme.
- filled  out  1  level == LEVEL_MAX.
- drained  out  1  level == 0.
- cycle_timeout  out  1  wash-cycle time elapsed; registered.
- spin_timeout  out  1  spin time elapsed; registered.
- level  out  8  current water level, zero-extended.
- wash_count  out  8  completed programmes; saturates at 255.

## Operation

- Prescaler: counts 0..TICK_DIV-1 while enable=1, then wraps to 0. tick is combinational and equals enable && (prescaler == TICK_DIV-1). With enable=0 the prescaler holds its value.
- Level register, updated only on tick:
  - fill_value_on=1, drain_value_on=0, level<LEVEL_MAX: level+1.
  - drain_value_on=1, fill_value_on=0, level>0: level-1.
  - Both valves on, neither on, or at a bound: hold. No wrap is permitted.
- filled and drained decode combinationally from the level register.
- Cycle timer:
  - While motor_on=1: cycle_cnt increments on tick, saturating at CYCLE_TICKS.
  - cycle_timeout sets on the edge where a tick brings cycle_cnt to CYCLE_TICKS.
  - motor_on=0 clears cycle_cnt and cycle_timeout on the next edge, regardless of tick.
- Spin timer:
  - Spin is defined as drain_value_on && drained.
  - While spinning: spin_cnt increments on tick, saturating at SPIN_TICKS.
  - spin_timeout sets on the edge where spin_cnt reaches SPIN_TICKS.
  - Leaving the spin condition clears spin_cnt and spin_timeout on the next edge.
- done:
  - A rising edge of done (registered compare against done_d) increments wash_count, saturating at 255.
  - The same edge clears cycle_cnt, spin_cnt, cycle_timeout and spin_timeout.
  - level is unaffected.
  - A held done counts once.
- Priority: reset > done clear > motor/spin clear > tick update.

## Timing

- Reset values:
  - prescaler, level, cycle_cnt, spin_cnt, wash_count, done_d: 0.
  - Outputs: filled=0, drained=1, cycle_timeout=0, spin_timeout=0, level=0, wash_count=0.
- Asynchronous reset takes effect immediately, including mid-fill or mid-cycle. Release is synchronous to clk.
- Level latency: one step per TICK_DIV clocks. The first step occurs between 1 and TICK_DIV clocks after a valve opens, depending on prescaler phase.
- A full fill from empty takes LEVEL_MAX ticks.
- cycle_timeout rises CYCLE_TICKS ticks after motor_on rises, within one tick of phase jitter.
- spin_timeout rises SPIN_TICKS ticks after the spin condition starts, within one tick of phase jitter.
- Both timeouts fall exactly 1 clock after their enabling condition drops.
- With TICK_DIV=1 every enabled clock is a tick, so all latencies are exact.
- Timeouts are level signals and stay high until cleared. They do not pulse.

## Test plan

All scenarios use TICK_DIV=1, LEVEL_MAX=4, CYCLE_TICKS=3, SPIN_TICKS=2, enable=1 unless stated.

1. Assert reset with all inputs 0 -> drained=1; filled=0; both timeouts 0; level=0; wash_count=0.
2. fill_value_on=1 for 6 clocks -> level reads 1,2,3,4,4,4; filled=1 from the 4th edge; drained=0 from the 1st edge. Assert reset mid-fill at level 2 -> level=0 immediately.
3. motor_on=1 for 5 clocks -> cycle_timeout=1 after the 3rd edge and held. Then motor_on=0 -> cycle_timeout=0 after 1 edge.
4. Start at level 4, drain_value_on=1 -> drained=1 after the 4th edge, spin_timeout=1 two edges later. Then drop drain_value_on -> spin_timeout=0 after 1 edge.
5. Both valves on at level 2 for 5 clocks -> level stays 2. Then enable=0 with fill on for 5 clocks -> level stays 2 and motor timer does not advance.
6. Pulse done 300 times, each high 2 clocks -> wash_count saturates at 255. Pulse done during motor_on with cycle_cnt=2 -> cycle_cnt cleared, timeout needs 3 fresh ticks.

Source files
------------

// File: rtl/wm_sense_timer.sv
// Plant model for the washing-machine controller: water level, wash-cycle and spin timers on a prescaled tick.
// Status outputs are registered state or decodes of registered state; there is no backpressure.
module wm_sense_timer #(
  parameter int TICK_DIV    = 10,
  parameter int LEVEL_MAX   = 20,
  parameter int CYCLE_TICKS = 100,
  parameter int SPIN_TICKS  = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       motor_on,
  input  logic       fill_value_on,
  input  logic       drain_value_on,
  input  logic       done,
  output logic       filled,
  output logic       drained,
  output logic       cycle_timeout,
  output logic       spin_timeout,
  output logic [7:0] level,
  output logic [7:0] wash_count
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(CYCLE_TICKS + 1);
  localparam int SW = $clog2(SPIN_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]    LVL_FULL   = 8'(LEVEL_MAX);
  localparam logic [CW-1:0] CYC_MAX    = CW'(CYCLE_TICKS);
  localparam logic [CW-1:0] CYC_PRE    = CW'(CYCLE_TICKS - 1);
  localparam logic [SW-1:0] SPIN_MAX   = SW'(SPIN_TICKS);
  localparam logic [SW-1:0] SPIN_PRE   = SW'(SPIN_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    level_q, level_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [SW-1:0] spin_cnt_q, spin_cnt_d;
  logic          cyc_to_q, cyc_to_d;
  logic          spin_to_q, spin_to_d;
  logic [7:0]    wash_q, wash_d;
  logic          done_q;

  logic tick;
  logic done_rise;
  logic spinning;

  assign tick      = enable && (presc_q == PRESC_LAST);
  assign done_rise = done && !done_q;
  assign spinning  = drain_value_on && (level_q == 8'd0);

  always_comb begin
    presc_d = presc_q;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  // Opposing valves cancel; the level never wraps past either bound.
  always_comb begin
    level_d = level_q;
    if (tick) begin
      if (fill_value_on && !drain_value_on && (level_q < LVL_FULL)) begin
        level_d = level_q + 8'd1;
      end else if (drain_value_on && !fill_value_on && (level_q != 8'd0)) begin
        level_d = level_q - 8'd1;
      end
    end
  end

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    cyc_to_d  = cyc_to_q;
    if (done_rise || !motor_on) begin
      cyc_cnt_d = '0;
      cyc_to_d  = 1'b0;
    end else if (tick && (cyc_cnt_q != CYC_MAX)) begin
      cyc_cnt_d = cyc_cnt_q + CW'(1);
      if (cyc_cnt_q == CYC_PRE) begin
        cyc_to_d = 1'b1;
      end
    end
  end

  always_comb begin
    spin_cnt_d = spin_cnt_q;
    spin_to_d  = spin_to_q;
    if (done_rise || !spinning) begin
      spin_cnt_d = '0;
      spin_to_d  = 1'b0;
    end else if (tick && (spin_cnt_q != SPIN_MAX)) begin
      spin_cnt_d = spin_cnt_q + SW'(1);
      if (spin_cnt_q == SPIN_PRE) begin
        spin_to_d = 1'b1;
      end
    end
  end

  always_comb begin
    wash_d = wash_q;
    if (done_rise && (wash_q != 8'hFF)) begin
      wash_d = wash_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      level_q    <= 8'd0;
      cyc_cnt_q  <= '0;
      spin_cnt_q <= '0;
      cyc_to_q   <= 1'b0;
      spin_to_q  <= 1'b0;
      wash_q     <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      level_q    <= level_d;
      cyc_cnt_q  <= cyc_cnt_d;
      spin_cnt_q <= spin_cnt_d;
      cyc_to_q   <= cyc_to_d;
      spin_to_q  <= spin_to_d;
      wash_q     <= wash_d;
      done_q     <= done;
    end
  end

  assign filled        = (level_q == LVL_FULL);
  assign drained       = (level_q == 8'd0);
  assign cycle_timeout = cyc_to_q;
  assign spin_timeout  = spin_to_q;
  assign level         = level_q;
  assign wash_count    = wash_q;

endmodule

// File: tb/tb_wm_sense_timer.sv
// Directed bench for wm_sense_timer: vector table for level/timer behaviour plus sequences for reset, done and prescaling.
module tb_wm_sense_timer;

  logic       clk = 1'b0;
  logic       reset, enable, motor_on, fill_value_on, drain_value_on, done;
  logic       filled, drained, cycle_timeout, spin_timeout;
  logic [7:0] level, wash_count;

  logic       b_reset, b_enable, b_fill;
  logic       b_filled, b_drained, b_cto, b_sto;
  logic [7:0] b_level, b_wash;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wm_sense_timer #(.TICK_DIV(1), .LEVEL_MAX(4), .CYCLE_TICKS(3), .SPIN_TICKS(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .motor_on(motor_on),
    .fill_value_on(fill_value_on), .drain_value_on(drain_value_on), .done(done),
    .filled(filled), .drained(drained), .cycle_timeout(cycle_timeout),
    .spin_timeout(spin_timeout), .level(level), .wash_count(wash_count)
  );

  wm_sense_timer #(.TICK_DIV(3), .LEVEL_MAX(4), .CYCLE_TICKS(3), .SPIN_TICKS(2)) dut_b (
    .clk(clk), .reset(b_reset), .enable(b_enable), .motor_on(1'b0),
    .fill_value_on(b_fill), .drain_value_on(1'b0), .done(1'b0),
    .filled(b_filled), .drained(b_drained), .cycle_timeout(b_cto),
    .spin_timeout(b_sto), .level(b_level), .wash_count(b_wash)
  );

  typedef struct {
    logic       en, fill, drain, motor;
    logic [7:0] lvl;
    logic       fld, drn, cto, sto;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic fill, logic drain, logic motor,
                              logic [7:0] lvl, logic fld, logic drn, logic cto, logic sto);
    vec_t v;
    v.en = en; v.fill = fill; v.drain = drain; v.motor = motor;
    v.lvl = lvl; v.fld = fld; v.drn = drn; v.cto = cto; v.sto = sto;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] lvl, input logic fld,
                         input logic drn, input logic cto, input logic sto);
    chk({tag, ".level"}, level, lvl);
    chk({tag, ".filled"}, {7'd0, filled}, {7'd0, fld});
    chk({tag, ".drained"}, {7'd0, drained}, {7'd0, drn});
    chk({tag, ".cycle_timeout"}, {7'd0, cycle_timeout}, {7'd0, cto});
    chk({tag, ".spin_timeout"}, {7'd0, spin_timeout}, {7'd0, sto});
  endtask

  initial begin
    // fill from empty to full and beyond
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 2,0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 3,0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 4,1,0,0,0));
    tbl.push_back(mk(1,1,0,0, 4,1,0,0,0));
    tbl.push_back(mk(1,1,0,0, 4,1,0,0,0));
    // drain to empty, then spin until timeout, then leave spin
    tbl.push_back(mk(1,0,1,0, 3,0,0,0,0));
    tbl.push_back(mk(1,0,1,0, 2,0,0,0,0));
    tbl.push_back(mk(1,0,1,0, 1,0,0,0,0));
    tbl.push_back(mk(1,0,1,0, 0,0,1,0,0));
    tbl.push_back(mk(1,0,1,0, 0,0,1,0,0));
    tbl.push_back(mk(1,0,1,0, 0,0,1,0,1));
    tbl.push_back(mk(1,0,1,0, 0,0,1,0,1));
    tbl.push_back(mk(1,0,0,0, 0,0,1,0,0));
    // motor run to timeout, held, then dropped
    tbl.push_back(mk(1,0,0,1, 0,0,1,0,0));
    tbl.push_back(mk(1,0,0,1, 0,0,1,0,0));
    tbl.push_back(mk(1,0,0,1, 0,0,1,1,0));
    tbl.push_back(mk(1,0,0,1, 0,0,1,1,0));
    tbl.push_back(mk(1,0,0,1, 0,0,1,1,0));
    tbl.push_back(mk(1,0,0,0, 0,0,1,0,0));
    // fill to 2, both valves hold
    tbl.push_back(mk(1,1,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1,1,0,0, 2,0,0,0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1,1,1,0, 2,0,0,0,0));
    // enable low freezes level and motor timer
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,1,0,1, 2,0,0,0,0));
    tbl.push_back(mk(1,0,0,1, 2,0,0,0,0));
    tbl.push_back(mk(1,0,0,1, 2,0,0,0,0));
    tbl.push_back(mk(1,0,0,1, 2,0,0,1,0));
    tbl.push_back(mk(1,0,0,0, 2,0,0,0,0));

    reset = 1'b1; enable = 1'b1; motor_on = 1'b0; fill_value_on = 1'b0;
    drain_value_on = 1'b0; done = 1'b0;
    b_reset = 1'b1; b_enable = 1'b0; b_fill = 1'b0;
    #1;
    chk_all("reset", 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset.wash_count", wash_count, 8'd0);
    edge1;
    reset = 1'b0; b_reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      enable = tbl[i].en; fill_value_on = tbl[i].fill;
      drain_value_on = tbl[i].drain; motor_on = tbl[i].motor;
      edge1;
      chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].fld, tbl[i].drn, tbl[i].cto, tbl[i].sto);
      chk($sformatf("vec%0d.wash_count", i), wash_count, 8'd0);
    end

    // asynchronous reset in the middle of a fill
    fill_value_on = 1'b1;
    edge1;
    chk("midfill.level_pre", level, 8'd3);
    #2 reset = 1'b1;
    #1;
    chk("midfill.level_async", level, 8'd0);
    chk("midfill.drained_async", {7'd0, drained}, 8'd1);
    #1 reset = 1'b0;
    edge1;
    edge1;
    chk("midfill.refill", level, 8'd2);
    fill_value_on = 1'b0;

    // done pulses saturate wash_count; held done counts once; level untouched
    for (int k = 1; k <= 300; k++) begin
      done = 1'b1;
      edge1;
      chk($sformatf("done%0d.rise", k), wash_count, (k > 255) ? 8'd255 : 8'(k));
      edge1;
      chk($sformatf("done%0d.held", k), wash_count, (k > 255) ? 8'd255 : 8'(k));
      done = 1'b0;
      edge1;
    end
    chk("done.level_kept", level, 8'd2);

    // done during a motor cycle restarts the timer
    motor_on = 1'b1;
    edge1;
    edge1;
    chk("cycdone.pre", {7'd0, cycle_timeout}, 8'd0);
    done = 1'b1;
    edge1;
    chk("cycdone.clear", {7'd0, cycle_timeout}, 8'd0);
    done = 1'b0;
    edge1;
    chk("cycdone.fresh1", {7'd0, cycle_timeout}, 8'd0);
    edge1;
    chk("cycdone.fresh2", {7'd0, cycle_timeout}, 8'd0);
    edge1;
    chk("cycdone.fresh3", {7'd0, cycle_timeout}, 8'd1);
    motor_on = 1'b0;
    edge1;
    chk("cycdone.drop", {7'd0, cycle_timeout}, 8'd0);

    // done during spin clears the spin timeout and restarts it
    drain_value_on = 1'b1;
    edge1;
    edge1;
    chk("spindone.empty", level, 8'd0);
    edge1;
    edge1;
    chk("spindone.to", {7'd0, spin_timeout}, 8'd1);
    done = 1'b1;
    edge1;
    chk("spindone.clear", {7'd0, spin_timeout}, 8'd0);
    done = 1'b0;
    edge1;
    chk("spindone.fresh1", {7'd0, spin_timeout}, 8'd0);
    edge1;
    chk("spindone.fresh2", {7'd0, spin_timeout}, 8'd1);
    drain_value_on = 1'b0;

    // prescaled instance: one level step every third enabled clock
    b_enable = 1'b1; b_fill = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      edge1;
      chk($sformatf("presc%0d.level", k), b_level, 8'(k / 3));
    end
    b_enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      edge1;
      chk($sformatf("freeze%0d.level", k), b_level, 8'd3);
    end
    b_enable = 1'b1;
    edge1;
    chk("resume1.level", b_level, 8'd3);
    edge1;
    chk("resume2.level", b_level, 8'd4);
    chk("resume2.filled", {7'd0, b_filled}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
